matrix_scroll_buffer: RTL and testbench

Upstream pattern source for the 8x8 LED matrix row scanner. Holds a double-banked 16-row pattern store and a scroll offset advanced by a programmable prescaler. Returns the byte for any requested display row (0..7) as front[(offset+row) mod 16]. A host writes new patterns into the back bank through a valid/ready port and commits them tear-free at a scroll boundary.

---
 rtl/matrix_scroll_buffer_if.sv | 11 +
 rtl/matrix_scroll_buffer.sv | 90 +++++++++
 tb/tb_matrix_scroll_buffer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_scroll_buffer_if.sv
// Host write port of the scroll buffer: back-bank row writes plus the commit request.
interface matrix_scroll_buffer_if;
    logic       valid;
    logic       ready;
    logic [3:0] addr;
    logic [7:0] data;
    logic       commit;

    modport master (output valid, output addr, output data, output commit, input ready);
    modport slave  (input valid, input addr, input data, input commit, output ready);
endinterface

// File: rtl/matrix_scroll_buffer.sv
// Double-banked 16-row pattern store with prescaled scroll offset; serves
// front[(offset+row) mod 16] to the row scanner and swaps banks tear-free.
module matrix_scroll_buffer #(
    parameter int unsigned STEP_DIV = 12500000,
    parameter logic [7:0]  BLANK    = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         scroll_en,
    input  logic                         scroll_dir,
    matrix_scroll_buffer_if.slave        wr,
    input  logic [2:0]                   rd_row,
    output logic [7:0]                   rd_data,
    output logic [3:0]                   offset,
    output logic                         step_pulse
);

    localparam int                CNT_W    = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

    logic [7:0]       bank [2][16];
    logic             bank_sel;
    logic             back_sel;
    logic             swap_pending;
    logic [CNT_W-1:0] count;
    logic             step_tick;
    logic             swap;
    logic             write_en;
    logic [3:0]       rd_idx;

    function automatic logic [3:0] next_offset(input logic [3:0] cur, input logic dir);
        return dir ? cur - 4'd1 : cur + 4'd1;
    endfunction

    assign step_tick = scroll_en && (count == CNT_LAST);
    // With scrolling stopped there is no boundary to wait for, so swap at once.
    assign swap      = swap_pending && (step_tick || !scroll_en);
    assign wr.ready  = ~swap_pending;
    assign write_en  = wr.valid && wr.ready;
    assign back_sel  = ~bank_sel;
    assign rd_idx    = offset + {1'b0, rd_row};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count        <= '0;
            offset       <= 4'd0;
            bank_sel     <= 1'b0;
            swap_pending <= 1'b0;
            step_pulse   <= 1'b0;
        end else begin
            step_pulse <= step_tick || swap;
            if (swap) begin
                count        <= '0;
                offset       <= 4'd0;
                bank_sel     <= ~bank_sel;
                swap_pending <= 1'b0;
            end else begin
                if (!scroll_en || step_tick) begin
                    count <= '0;
                end else begin
                    count <= count + CNT_W'(1);
                end
                if (step_tick) begin
                    offset <= next_offset(offset, scroll_dir);
                end
                if (wr.commit) begin
                    swap_pending <= 1'b1;
                end
            end
        end
    end

    // Pattern store and registered read port; reads use pre-edge offset/bank_sel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int r = 0; r < 16; r++) begin
                    bank[b][r] <= BLANK;
                end
            end
            rd_data <= BLANK;
        end else begin
            if (write_en) begin
                bank[back_sel][wr.addr] <= wr.data;
            end
            rd_data <= bank[bank_sel][rd_idx];
        end
    end

endmodule

// File: tb/tb_matrix_scroll_buffer.sv
// Directed-vector bench for matrix_scroll_buffer with STEP_DIV = 4.
module tb_matrix_scroll_buffer;

    logic       clk;
    logic       reset;
    logic       scroll_en;
    logic       scroll_dir;
    logic [2:0] rd_row;
    logic [7:0] rd_data;
    logic [3:0] offset;
    logic       step_pulse;
    int         n_assert;
    int         n_fail;

    matrix_scroll_buffer_if wr_bus ();

    matrix_scroll_buffer #(
        .STEP_DIV (4),
        .BLANK    (8'hFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scroll_en  (scroll_en),
        .scroll_dir (scroll_dir),
        .wr         (wr_bus),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .offset     (offset),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_assert        = 0;
        n_fail          = 0;
        reset           = 1'b0;
        scroll_en       = 1'b0;
        scroll_dir      = 1'b0;
        rd_row          = 3'd0;
        wr_bus.valid    = 1'b0;
        wr_bus.addr     = 4'd0;
        wr_bus.data     = 8'd0;
        wr_bus.commit   = 1'b0;

        // Reset state
        #12;
        check("rst_rd_data", rd_data, 8'hFF);
        check("rst_offset", offset, 8'd0);
        check("rst_wr_ready", wr_bus.ready, 8'd1);
        check("rst_step_pulse", step_pulse, 8'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd_row = 3'(i);
            tick(1);
            check("blank_read", rd_data, 8'hFF);
        end
        check("idle_offset", offset, 8'd0);

        // Fill back bank with back[k] = k
        for (int k = 0; k < 16; k++) begin
            wr_bus.valid = 1'b1;
            wr_bus.addr  = 4'(k);
            wr_bus.data  = 8'(k);
            tick(1);
        end
        wr_bus.valid = 1'b0;
        rd_row = 3'd3;
        tick(1);
        check("front_untouched", rd_data, 8'hFF);

        // Commit with scrolling stopped: swap one cycle later
        wr_bus.commit = 1'b1;
        tick(1);
        wr_bus.commit = 1'b0;
        check("pending_ready_low", wr_bus.ready, 8'd0);
        check("pending_no_pulse", step_pulse, 8'd0);
        tick(1);
        check("swap_pulse", step_pulse, 8'd1);
        check("swap_offset", offset, 8'd0);
        check("swap_ready_high", wr_bus.ready, 8'd1);
        tick(1);
        check("swap_read_row3", rd_data, 8'h03);
        check("pulse_one_cycle", step_pulse, 8'd0);

        // Scrolling forward, one step per 4 clocks
        scroll_en  = 1'b1;
        scroll_dir = 1'b0;
        tick(3);
        check("no_early_step", offset, 8'd0);
        tick(1);
        check("first_step", offset, 8'd1);
        check("step_pulse", step_pulse, 8'd1);
        for (int s = 2; s <= 14; s++) begin
            tick(4);
            check("offset_inc", offset, 8'(s));
        end
        rd_row = 3'd5;
        tick(1);
        check("wrap_read_14_5", rd_data, 8'h03);
        check("hold_offset14", offset, 8'd14);
        tick(3);
        check("offset15", offset, 8'd15);
        tick(4);
        check("wrap_15_to_0", offset, 8'd0);
        scroll_dir = 1'b1;
        tick(4);
        check("wrap_0_to_15", offset, 8'd15);

        // Commit mid-interval while scrolling
        tick(1);
        wr_bus.commit = 1'b1;
        tick(1);
        wr_bus.commit = 1'b0;
        wr_bus.valid  = 1'b1;
        wr_bus.addr   = 4'd0;
        wr_bus.data   = 8'hAA;
        check("mid_ready_low", wr_bus.ready, 8'd0);
        tick(1);
        wr_bus.commit = 1'b1;
        check("mid_ready_still_low", wr_bus.ready, 8'd0);
        check("mid_offset_held", offset, 8'd15);
        tick(1);
        wr_bus.commit = 1'b0;
        wr_bus.valid  = 1'b0;
        check("boundary_swap_offset", offset, 8'd0);
        check("boundary_swap_pulse", step_pulse, 8'd1);
        check("no_second_pending", wr_bus.ready, 8'd1);
        rd_row = 3'd0;
        tick(1);
        check("blocked_write", rd_data, 8'hFF);
        check("post_swap_offset", offset, 8'd0);
        tick(3);
        check("scroll_after_swap", offset, 8'd15);
        check("still_ready", wr_bus.ready, 8'd1);

        // Old front became back bank; rewrite one row
        scroll_en    = 1'b0;
        wr_bus.valid = 1'b1;
        wr_bus.addr  = 4'd2;
        wr_bus.data  = 8'h55;
        tick(1);
        wr_bus.valid = 1'b0;
        rd_row = 3'd3;
        tick(1);
        check("front_keeps_old", rd_data, 8'hFF);
        wr_bus.commit = 1'b1;
        tick(1);
        wr_bus.commit = 1'b0;
        tick(1);
        check("second_swap_offset", offset, 8'd0);
        rd_row = 3'd2;
        tick(1);
        check("new_row2", rd_data, 8'h55);
        rd_row = 3'd3;
        tick(1);
        check("retained_row3", rd_data, 8'h03);

        // Reset with a pending commit at offset 9
        scroll_en  = 1'b1;
        scroll_dir = 1'b0;
        tick(36);
        check("offset9", offset, 8'd9);
        rd_row = 3'd0;
        wr_bus.commit = 1'b1;
        tick(1);
        wr_bus.commit = 1'b0;
        check("pre_reset_pending", wr_bus.ready, 8'd0);
        check("pre_reset_read", rd_data, 8'h09);
        #3;
        reset     = 1'b0;
        scroll_en = 1'b0;
        #1;
        check("async_rd_data", rd_data, 8'hFF);
        check("async_offset", offset, 8'd0);
        check("async_wr_ready", wr_bus.ready, 8'd1);
        check("async_step_pulse", step_pulse, 8'd0);
        #2 reset = 1'b1;
        tick(1);
        check("no_swap_after_reset", step_pulse, 8'd0);
        check("offset_after_reset", offset, 8'd0);
        rd_row = 3'd3;
        tick(1);
        check("bank_blank_after_reset", rd_data, 8'hFF);
        check("no_late_swap", step_pulse, 8'd0);
        check("ready_after_reset", wr_bus.ready, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
